// File: rtl/wb_unit_pkg.sv
// ---------------------------------------------------------------------------
// wb_unit_pkg
// Shared constants and types for the write-back unit:
//   XLEN       - register / data width
//   REG_AW     - register-file address width
//   load_f3_e  - RISC-V load funct3 encodings (LB/LH/LW/LBU/LHU)
//   lq_entry_t - one load-queue entry {rd, funct3, addr_lo}
// ---------------------------------------------------------------------------
package wb_unit_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
  } lq_entry_t;

endpackage

// File: rtl/wb_unit_if.sv
// ---------------------------------------------------------------------------
// wb_unit_if
// Bundles every non-clock/reset signal of wb_unit.
//   master : drives ALU result, load issue, memory response, decode sources
//   slave  : wb_unit side; drives handshakes, stall, both RF write ports, err
// ---------------------------------------------------------------------------
interface wb_unit_if;
  import wb_unit_pkg::*;

  // ALU result
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_result;
  // Load issue
  logic              ld_issue;
  logic [REG_AW-1:0] ld_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr_lo;
  logic              ld_ready;
  // Memory response
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_rready;
  // Decode hazard check
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              ld_stall;
  // Register-file write ports
  logic              write_en;
  logic [REG_AW-1:0] write_addr;
  logic [XLEN-1:0]   write_data;
  logic              mem_write_en;
  logic [REG_AW-1:0] mem_write_addr;
  logic [XLEN-1:0]   mem_write_data;
  // Sticky protocol error
  logic              err;

  modport master (
    output ex_valid, ex_rd, ex_result,
    output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    output mem_rvalid, mem_rdata,
    output rs1_addr, rs2_addr,
    input  ld_ready, mem_rready, ld_stall,
    input  write_en, write_addr, write_data,
    input  mem_write_en, mem_write_addr, mem_write_data,
    input  err
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result,
    input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    input  mem_rvalid, mem_rdata,
    input  rs1_addr, rs2_addr,
    output ld_ready, mem_rready, ld_stall,
    output write_en, write_addr, write_data,
    output mem_write_en, mem_write_addr, mem_write_data,
    output err
  );

endinterface

// File: rtl/wb_unit_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data alignment.
//   data_i    : raw memory word
//   funct3_i  : load type
//   addr_lo_i : byte offset within the word
//   data_o    : aligned / extended value for the register file
// Optional feature macro: LOAD_ALIGN_EN. When undefined the raw word passes
// through untouched and funct3_i / addr_lo_i are ignored.
// ---------------------------------------------------------------------------
module load_align
  import wb_unit_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

`ifdef LOAD_ALIGN_EN
  // Only the low half-word of the shifted data is ever consumed.
  logic [15:0] shifted;
  assign shifted = 16'(data_i >> {addr_lo_i, 3'b000});

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LW:   data_o = data_i;
      default: data_o = data_i;
    endcase
  end
`else
  assign data_o = data_i;

  logic unused_fields;
  assign unused_fields = ^{funct3_i, addr_lo_i};
`endif

endmodule

// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit
// Write-back unit: registered ALU write port, in-order load queue, one-entry
// load hold register with ALU-priority arbitration, and load-use stall.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : wb_unit_if.slave (ALU result, load issue/response, decode sources,
//          both register-file write ports, sticky err)
// Parameter LQ_DEPTH : load-queue entries (power of two, 2..8).
// Optional feature macro: LOAD_ALIGN_EN (enables alignment in load_align).
// ---------------------------------------------------------------------------
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  wb_unit_if.slave bus
);

  localparam int              PTR_W    = $clog2(LQ_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(LQ_DEPTH);

  // ALU write port
  logic              write_en_q,   write_en_d;
  logic [REG_AW-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;

  // Load queue
  lq_entry_t         lq_mem [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] lq_vld_q, lq_vld_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;

  // Hold register
  logic              hold_vld_q,  hold_vld_d;
  logic [REG_AW-1:0] hold_rd_q,   hold_rd_d;
  logic [XLEN-1:0]   hold_data_q, hold_data_d;

  logic              err_q, err_d;

  logic              ld_ready, mem_rready, push, pop, retire;
  lq_entry_t         head_ent;
  logic [XLEN-1:0]   aligned_data;

  assign ld_ready   = (count_q != FULL_CNT);
  assign mem_rready = !hold_vld_q;
  assign push       = bus.ld_issue && ld_ready;
  assign pop        = bus.mem_rvalid && mem_rready && (count_q != '0);
  assign head_ent   = lq_mem[head_q];
  // An rd=0 entry never touches the RF port, so it may retire under an ALU write.
  assign retire     = hold_vld_q && ((hold_rd_q == '0) || !write_en_q);

  load_align u_load_align (
    .data_i    (bus.mem_rdata),
    .funct3_i  (head_ent.funct3),
    .addr_lo_i (head_ent.addr_lo),
    .data_o    (aligned_data)
  );

  always_comb begin
    write_en_d   = bus.ex_valid && (bus.ex_rd != '0);
    write_addr_d = write_en_d ? bus.ex_rd : '0;
    write_data_d = write_en_d ? bus.ex_result : '0;

    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    lq_vld_d = lq_vld_q;
    if (push) begin
      tail_d           = tail_q + 1'b1;
      lq_vld_d[tail_q] = 1'b1;
    end
    if (pop) begin
      head_d           = head_q + 1'b1;
      lq_vld_d[head_q] = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Pop only happens with the hold empty, so load and retire never collide.
    hold_vld_d  = hold_vld_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (pop) begin
      hold_vld_d  = 1'b1;
      hold_rd_d   = head_ent.rd;
      hold_data_d = aligned_data;
    end else if (retire) begin
      hold_vld_d  = 1'b0;
      hold_rd_d   = '0;
      hold_data_d = '0;
    end

    err_d = err_q
          | (bus.mem_rvalid && (count_q == '0))
          | (bus.ld_issue && !ld_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      lq_vld_q     <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      hold_vld_q   <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      lq_vld_q     <= lq_vld_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      hold_vld_q   <= hold_vld_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      err_q        <= err_d;
    end
  end

  // Queue payload needs no reset; validity is tracked by lq_vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem[tail_q] <= '{rd: bus.ld_rd, funct3: bus.ld_funct3, addr_lo: bus.ld_addr_lo};
    end
  end

  // Load-use hazard: any pending queue entry or the occupied hold entry.
  logic                rs1_nz, rs2_nz, hold_hit;
  logic [LQ_DEPTH-1:0] lq_hit;
  assign rs1_nz = (bus.rs1_addr != '0);
  assign rs2_nz = (bus.rs2_addr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < LQ_DEPTH; gi++) begin : g_lq_hit
      assign lq_hit[gi] = lq_vld_q[gi] &&
                          ((rs1_nz && (lq_mem[gi].rd == bus.rs1_addr)) ||
                           (rs2_nz && (lq_mem[gi].rd == bus.rs2_addr)));
    end
  endgenerate

  assign hold_hit = hold_vld_q &&
                    ((rs1_nz && (hold_rd_q == bus.rs1_addr)) ||
                     (rs2_nz && (hold_rd_q == bus.rs2_addr)));

  assign bus.ld_stall       = hold_hit || (|lq_hit);
  assign bus.ld_ready       = ld_ready;
  assign bus.mem_rready     = mem_rready;
  assign bus.write_en       = write_en_q;
  assign bus.write_addr     = write_addr_q;
  assign bus.write_data     = write_data_q;
  // The ALU port has priority; the load port is shown only when it may write.
  assign bus.mem_write_en   = hold_vld_q && (hold_rd_q != '0) && !write_en_q;
  assign bus.mem_write_addr = bus.mem_write_en ? hold_rd_q : '0;
  assign bus.mem_write_data = bus.mem_write_en ? hold_data_q : '0;
  assign bus.err            = err_q;

endmodule
